// File: rtl/iterative_divider_if.sv
// Start/done divide handshake bundle: operands and controls in, registered results out.
interface iterative_divider_if #(parameter int WIDTH = 64);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, ARMv8 UDIV/SDIV semantics
// (x/0 = 0 with remainder = dividend, MIN/-1 = MIN).
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  iterative_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sgn_r, q_sign, r_sign;
  logic [WIDTH-1:0] quo, dvs;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             ready, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // MIN's magnitude fits as an unsigned WIDTH-bit value, so plain negation suffices.
  assign a_mag  = (sgn_r && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_mag  = (sgn_r && b_r[WIDTH-1]) ? -b_r : b_r;
  assign diff   = {rem, quo[WIDTH-1]} - {2'b00, dvs};
  assign borrow = diff[WIDTH+1];
  assign q_fix  = q_sign ? -quo : quo;
  assign r_fix  = r_sign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sgn_r       <= 1'b0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      quo         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.flush && state != IDLE) begin
        state <= IDLE;
        ready <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.start && !bus.flush) begin
            a_r   <= bus.dividend;
            b_r   <= bus.divisor;
            sgn_r <= bus.is_signed;
            ready <= 1'b0;
            state <= PREP;
          end
          PREP: begin
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= CNT_W'(WIDTH);
            q_sign <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            r_sign <= sgn_r & a_r[WIDTH-1];
            if (b_r == '0) begin
              quotient    <= '0;
              remainder   <= a_r;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              state <= ITER;
            end
          end
          ITER: begin
            // Restore by keeping the shifted value when the trial subtract borrows.
            rem   <= borrow ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
            quo   <= {quo[WIDTH-2:0], ~borrow};
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
          DONE: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          default: begin
            ready <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.done        = done;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: directed ARMv8 corner cases on a 64-bit instance plus
// randomized back-to-back streams on 64- and 8-bit instances against an arithmetic model.
module tb_iterative_divider;
  logic clk = 1'b0;
  logic reset_n, rst8_n;
  int   errs = 0, checks = 0;
  logic [63:0] last_q = '0, last_r = '0;
  logic        last_z = 1'b0;

  typedef struct {bit s; logic [63:0] a; logic [63:0] b;} op_t;

  iterative_divider_if #(.WIDTH(64)) bus64();
  iterative_divider_if #(.WIDTH(8))  bus8();

  iterative_divider #(.WIDTH(64)) u64 (.clk(clk), .reset_n(reset_n), .bus(bus64));
  iterative_divider #(.WIDTH(8))  u8  (.clk(clk), .reset_n(rst8_n),  .bus(bus8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain / and % on sign-extended values, truncated to w bits.
  function automatic void ref_div(input bit s, input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit z);
    logic [63:0]        m;
    logic signed [63:0] sa, sb;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    z = 1'b0;
    if ((b & m) == 0) begin
      q = 0; r = a & m; z = 1'b1;
    end else if (!s) begin
      q = (a & m) / (b & m); r = (a & m) % (b & m);
    end else begin
      sa = a << (64 - w); sa = sa >>> (64 - w);
      sb = b << (64 - w); sb = sb >>> (64 - w);
      if (sb == -64'sd1) begin q = -sa; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
      q = q & m; r = r & m;
    end
  endfunction

  task automatic drive(input int w, input bit st, input bit s, input logic [63:0] a, input logic [63:0] b);
    if (w == 64) begin
      bus64.start = st; bus64.is_signed = s; bus64.dividend = a; bus64.divisor = b;
    end else begin
      bus8.start = st; bus8.is_signed = s; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end
  endtask

  task automatic peek(input int w, output bit dn, output bit rd, output bit z,
                      output logic [63:0] q, output logic [63:0] r);
    if (w == 64) begin
      dn = bus64.done; rd = bus64.ready; z = bus64.div_by_zero; q = bus64.quotient; r = bus64.remainder;
    end else begin
      dn = bus8.done; rd = bus8.ready; z = bus8.div_by_zero;
      q = {56'b0, bus8.quotient}; r = {56'b0, bus8.remainder};
    end
  endtask

  // One full operation on the 64-bit instance, checking latency, busy window and results.
  task automatic op64(input bit s, input logic [63:0] a, input logic [63:0] b, input string tag);
    logic [63:0] eq, er;
    bit          ez, rdy_bad;
    int          lat;
    ref_div(s, 64, a, b, eq, er, ez);
    @(negedge clk);
    drive(64, 1, s, a, b);
    @(negedge clk);
    drive(64, 0, ~s, ~a, a ^ b);
    lat = 0; rdy_bad = 0;
    while (!bus64.done && lat < 300) begin
      if (bus64.ready) rdy_bad = 1;
      @(negedge clk);
      lat++;
    end
    if (b == 0) chk({tag, "_lat"}, 64'(lat <= 2), 64'd1);
    else        chk({tag, "_lat"}, 64'(lat), 64'd66);
    chk({tag, "_busy"}, 64'(rdy_bad), 64'd0);
    chk({tag, "_q"}, bus64.quotient, eq);
    chk({tag, "_r"}, bus64.remainder, er);
    chk({tag, "_dz"}, 64'(bus64.div_by_zero), 64'(ez));
    @(negedge clk);
    chk({tag, "_pulse"}, {62'b0, bus64.done, bus64.ready}, 64'b01);
    last_q = eq; last_r = er; last_z = ez;
  endtask

  // Start held high every cycle with fresh operands; only accepted ones go to the scoreboard.
  task automatic stream(input int w, input int n, input string tag);
    op_t         pend[$];
    op_t         o;
    bit          dn, rd, z, ez;
    logic [63:0] q, r, eq, er, m;
    int          rb = 0;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int c = 0; c < n + w + 20; c++) begin
      @(negedge clk);
      peek(w, dn, rd, z, q, r);
      if (dn) begin
        if (pend.size() == 0) chk({tag, "_extra_done"}, 64'd1, 64'd0);
        else begin
          o = pend.pop_front();
          ref_div(o.s, w, o.a, o.b, eq, er, ez);
          chk({tag, "_q"}, q, eq);
          chk({tag, "_r"}, r, er);
          chk({tag, "_dz"}, 64'(z), 64'(ez));
        end
      end
      if (pend.size() != 0 && rd) rb++;
      if (c < n) begin
        o.s = 1'($urandom_range(1, 0));
        o.a = {$urandom, $urandom} & m;
        o.b = ({$urandom, $urandom} & m) >> $urandom_range(w - 1, 0);
        case ($urandom_range(7, 0))
          0: o.b = 0;
          1: o.b = m;
          2: begin o.a = 64'd1 << (w - 1); o.b = m; end
          default: ;
        endcase
        drive(w, 1, o.s, o.a, o.b);
        if (rd) pend.push_back(o);
      end else begin
        drive(w, 0, 0, 0, 0);
      end
    end
    chk({tag, "_busy"}, 64'(rb), 64'd0);
    chk({tag, "_left"}, 64'(pend.size()), 64'd0);
  endtask

  initial begin
    int nd;
    reset_n = 1'b0; rst8_n = 1'b0;
    drive(64, 0, 0, 0, 0); drive(8, 0, 0, 0, 0);
    bus64.flush = 1'b0; bus8.flush = 1'b0;
    #22;
    chk("rst_ready", 64'(bus64.ready), 64'd1);
    chk("rst_done",  64'(bus64.done), 64'd0);
    chk("rst_q",     bus64.quotient, 64'd0);
    chk("rst_r",     bus64.remainder, 64'd0);
    chk("rst_dz",    64'(bus64.div_by_zero), 64'd0);
    @(negedge clk); reset_n = 1'b1; rst8_n = 1'b1;

    op64(0, 64'd100, 64'd7, "udiv_100_7");
    op64(1, -64'sd100, 64'd7, "sdiv_n100_7");
    op64(1, 64'd100, -64'sd7, "sdiv_100_n7");
    op64(1, -64'sd100, -64'sd7, "sdiv_n100_n7");
    op64(0, 64'hDEAD, 64'd0, "udiv_by_zero");
    op64(0, 64'd10, 64'd3, "udiv_10_3");
    op64(1, 64'h8000_0000_0000_0000, '1, "sdiv_min_m1");
    op64(0, 64'h8000_0000_0000_0000, '1, "udiv_min_m1");
    op64(1, 64'h8000_0000_0000_0000, 64'd0, "sdiv_min_0");
    for (int i = 0; i < 8; i++)
      op64(1'($urandom_range(1, 0)), {$urandom, $urandom},
           {$urandom, $urandom} >> $urandom_range(63, 0), "rand64");

    // Flush mid-iteration: back to idle, no done, previous results kept.
    @(negedge clk); drive(64, 1, 0, 64'd50, 64'd5);
    @(negedge clk); drive(64, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    bus64.flush = 1'b1;
    @(negedge clk); bus64.flush = 1'b0;
    chk("flush_ready", 64'(bus64.ready), 64'd1);
    chk("flush_done",  64'(bus64.done), 64'd0);
    chk("flush_q",     bus64.quotient, last_q);
    chk("flush_r",     bus64.remainder, last_r);
    chk("flush_dz",    64'(bus64.div_by_zero), 64'(last_z));
    nd = 0;
    repeat (80) begin @(negedge clk); if (bus64.done) nd++; end
    chk("flush_no_done", 64'(nd), 64'd0);
    op64(0, 64'd50, 64'd5, "after_flush");

    // Flush beats a simultaneous start while idle.
    @(negedge clk); drive(64, 1, 0, 64'd9, 64'd3); bus64.flush = 1'b1;
    @(negedge clk); drive(64, 0, 0, 0, 0); bus64.flush = 1'b0;
    chk("flush_start_drop", 64'(bus64.ready), 64'd1);

    // Async reset mid-iteration clears outputs at once and produces no done.
    @(negedge clk); drive(64, 1, 0, 64'd1000, 64'd3);
    @(negedge clk); drive(64, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_q",     bus64.quotient, 64'd0);
    chk("midrst_r",     bus64.remainder, 64'd0);
    chk("midrst_dz",    64'(bus64.div_by_zero), 64'd0);
    chk("midrst_ready", 64'(bus64.ready), 64'd1);
    @(negedge clk); reset_n = 1'b1;
    nd = 0;
    repeat (80) begin @(negedge clk); if (bus64.done) nd++; end
    chk("midrst_no_done", 64'(nd), 64'd0);
    op64(1, -64'sd7, 64'd2, "after_reset");

    stream(64, 200, "hs64");
    stream(8, 3000, "hs8");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
